// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type, CBD sampler state encoding and a small popcount helper.
package kyber_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;

    typedef logic [11:0] coef_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cbd_state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/cbd_sampler_stream_if.sv
// Byte-in / coefficient-out valid-ready stream bundle for the CBD sampler.
interface cbd_sampler_stream_if #(
    parameter int COEF_W = 12
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [COEF_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/cbd_coef_unit.sv
// Combinational CBD_eta coefficient: popcount(low ETA bits) - popcount(high ETA bits).
// With CBD_MODQ_EN defined the result is the canonical residue mod KYBER_Q, otherwise two's complement.
module cbd_coef_unit
    import kyber_pkg::*;
#(
    parameter int ETA    = 2,
    parameter int COEF_W = 12
) (
    input  logic [2*ETA-1:0]  bits,
    output logic [COEF_W-1:0] coef_out
);

    localparam logic [COEF_W-1:0] Q_W = COEF_W'(KYBER_Q);

    logic [2:0]               a_bits_s;
    logic [2:0]               b_bits_s;
    logic [1:0]               a_s;
    logic [1:0]               b_s;
    logic signed [COEF_W-1:0] coef_s;

    // Popcount both halves and form the signed difference
    always_comb begin
        a_bits_s          = 3'b000;
        b_bits_s          = 3'b000;
        a_bits_s[ETA-1:0] = bits[ETA-1:0];
        b_bits_s[ETA-1:0] = bits[2*ETA-1:ETA];
        a_s               = popcount3(a_bits_s);
        b_s               = popcount3(b_bits_s);
        coef_s            = $signed(COEF_W'(a_s) - COEF_W'(b_s));
    end

    // Output encoding of the coefficient
    always_comb begin
`ifdef CBD_MODQ_EN
        if (coef_s[COEF_W-1]) begin
            coef_out = $unsigned(coef_s) + Q_W;
        end else begin
            coef_out = $unsigned(coef_s);
        end
`else
        coef_out = $unsigned(coef_s);
`endif
    end

endmodule

// File: rtl/cbd_sampler_stream.sv
// Streaming CBD_eta sampler: 64*ETA PRF bytes in, N coefficients out, both over valid/ready.
// Optional build macro CBD_MODQ_EN selects mod-q residue output instead of two's complement.
module cbd_sampler_stream
    import kyber_pkg::*;
#(
    parameter int ETA    = 2,
    parameter int N      = KYBER_N,
    parameter int COEF_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    cbd_sampler_stream_if.slave   strm,
    output logic                  busy,
    output logic                  done
);

    localparam int              CBW    = 2 * ETA;
    localparam logic [4:0]      CB_W   = 5'(CBW);
    localparam logic [7:0]      BYTES  = 8'(64 * ETA);
    localparam logic [8:0]      N_W    = 9'(N);

    generate
        if (ETA != 2 && ETA != 3) begin : g_eta_check
            $error("cbd_sampler_stream: ETA must be 2 or 3");
        end
    endgenerate

    cbd_state_e        state_r;
    logic              busy_r;
    logic              done_r;
    logic [15:0]       buf_r;
    logic [4:0]        bit_cnt_r;
    logic [7:0]        byte_cnt_r;
    logic [8:0]        coef_cnt_r;
    logic [COEF_W-1:0] m_data_r;
    logic              m_valid_r;
    logic              m_last_r;

    logic              go_s;
    logic              ready_s;
    logic              push_s;
    logic              pop_s;
    logic [4:0]        push_pos_s;
    logic [15:0]       buf_nxt_s;
    logic [4:0]        bit_cnt_nxt_s;
    logic [COEF_W-1:0] coef_data_s;

    assign go_s    = (state_r == IDLE) && start;
    // s_ready depends on registers only, so it never loops through m_ready.
    assign ready_s = (state_r == RUN) && (byte_cnt_r < BYTES) && (bit_cnt_r < CB_W);
    assign push_s  = ready_s && strm.s_valid;
    assign pop_s   = (state_r == RUN) && (!m_valid_r || strm.m_ready)
                     && (bit_cnt_r >= CB_W) && (coef_cnt_r < N_W);

    cbd_coef_unit #(
        .ETA    (ETA),
        .COEF_W (COEF_W)
    ) u_coef (
        .bits     (buf_r[CBW-1:0]),
        .coef_out (coef_data_s)
    );

    // Next bit-buffer contents: pop shifts out one coefficient, push lands above the remaining bits
    always_comb begin
        buf_nxt_s     = buf_r;
        push_pos_s    = bit_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        if (pop_s) begin
            buf_nxt_s     = buf_r >> CBW;
            push_pos_s    = bit_cnt_r - CB_W;
            bit_cnt_nxt_s = bit_cnt_r - CB_W;
        end else begin
            push_pos_s    = bit_cnt_r;
        end
        if (push_s) begin
            buf_nxt_s     = buf_nxt_s | (16'(strm.s_data) << push_pos_s);
            bit_cnt_nxt_s = bit_cnt_nxt_s + 5'd8;
        end else begin
            buf_nxt_s     = buf_nxt_s;
        end
    end

    // Control FSM with registered busy/done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    if (m_valid_r && strm.m_ready && m_last_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Bit buffer, byte/coefficient counters and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_r      <= 16'h0000;
            bit_cnt_r  <= 5'd0;
            byte_cnt_r <= 8'd0;
            coef_cnt_r <= 9'd0;
            m_data_r   <= '0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else if (go_s) begin
            buf_r      <= 16'h0000;
            bit_cnt_r  <= 5'd0;
            byte_cnt_r <= 8'd0;
            coef_cnt_r <= 9'd0;
            m_data_r   <= '0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else begin
            buf_r     <= buf_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            if (push_s) begin
                byte_cnt_r <= byte_cnt_r + 8'd1;
            end
            if (pop_s) begin
                coef_cnt_r <= coef_cnt_r + 9'd1;
                m_data_r   <= coef_data_s;
                m_valid_r  <= 1'b1;
                m_last_r   <= (coef_cnt_r == N_W - 9'd1);
            end else if (strm.m_ready) begin
                m_valid_r  <= 1'b0;
                m_last_r   <= 1'b0;
            end
        end
    end

    assign strm.s_ready = ready_s;
    assign strm.m_data  = m_data_r;
    assign strm.m_valid = m_valid_r;
    assign strm.m_last  = m_last_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_cbd_sampler_stream.sv
// Self-checking bench for cbd_sampler_stream: ETA=2 and ETA=3 instances against a bit-stream reference model.
module tb_cbd_sampler_stream;
    import kyber_pkg::*;

    localparam int NC = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       sel;
    logic [7:0] s_data;
    logic       s_valid;
    logic       m_ready;
    logic       busy2, done2, busy3, done3;

    cbd_sampler_stream_if #(.COEF_W(12)) if2 ();
    cbd_sampler_stream_if #(.COEF_W(12)) if3 ();

    assign if2.s_data  = s_data;
    assign if2.s_valid = s_valid;
    assign if2.m_ready = m_ready;
    assign if3.s_data  = s_data;
    assign if3.s_valid = s_valid;
    assign if3.m_ready = m_ready;

    cbd_sampler_stream #(.ETA(2), .N(NC), .COEF_W(12)) dut2 (
        .clk(clk), .reset(reset), .start(start && !sel), .strm(if2.slave), .busy(busy2), .done(done2));
    cbd_sampler_stream #(.ETA(3), .N(NC), .COEF_W(12)) dut3 (
        .clk(clk), .reset(reset), .start(start && sel), .strm(if3.slave), .busy(busy3), .done(done3));

    logic        o_s_ready, o_m_valid, o_m_last, o_busy, o_done;
    logic [11:0] o_m_data;
    assign o_s_ready = sel ? if3.s_ready : if2.s_ready;
    assign o_m_valid = sel ? if3.m_valid : if2.m_valid;
    assign o_m_last  = sel ? if3.m_last  : if2.m_last;
    assign o_m_data  = sel ? if3.m_data  : if2.m_data;
    assign o_busy    = sel ? busy3 : busy2;
    assign o_done    = sel ? done3 : done2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src[$];
    logic [11:0] exp_q[$];
    logic [11:0] got[$];

    function automatic logic [11:0] enc(input int c);
`ifdef CBD_MODQ_EN
        if (c < 0) return 12'(KYBER_Q + c);
        return 12'(c);
`else
        return 12'(c);
`endif
    endfunction

    // Coefficient k uses stream bits [k*2eta, k*2eta+2eta), bytes read LSB-first.
    function automatic void build_exp(input int eta);
        exp_q.delete();
        for (int k = 0; k < NC; k++) begin
            int a = 0;
            int b = 0;
            for (int j = 0; j < 2 * eta; j++) begin
                int idx = k * 2 * eta + j;
                logic [7:0] by = src[idx / 8];
                int bv = int'(by[idx % 8]);
                if (j < eta) a += bv; else b += bv;
            end
            exp_q.push_back(enc(a - b));
        end
    endfunction

    task automatic fill_random(input int nbytes);
        src.delete();
        for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
    endtask

    task automatic run_poly(input int eta, input int pv, input int pr, input int stall_at,
                            input int abort_at, input int restart_at);
        int nb = 64 * eta;
        int cb = 2 * eta;
        int m_bytes = 0, m_loaded = 0, hs = 0, cyc = 0, stall = 0, bits;
        bit m_mv = 1'b0, hold = 1'b0, stalled = 1'b0, rdy_e, acc, pop;
        logic [11:0] hold_data = 12'h000;
        sel = (eta == 3);
        got.delete();
        build_exp(eta);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", o_busy); end
        while (hs < NC && cyc < 20000 && errors < 40) begin
            if (abort_at >= 0 && hs >= abort_at) return;
            if (hold) begin
                checks++;
                if (o_m_valid !== 1'b1 || o_m_data !== hold_data) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b d=%h expected v=1 d=%h", o_m_valid, o_m_data, hold_data);
                end
            end
            if (stall_at >= 0 && !stalled && hs == stall_at) begin stall = 5; stalled = 1'b1; end
            s_valid = ($urandom_range(99) < pv);
            s_data  = (m_bytes < nb) ? src[m_bytes] : 8'($urandom);
            m_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < pr);
            if (stall > 0) stall--;
            start   = (restart_at >= 0 && hs == restart_at);
            bits  = 8 * m_bytes - cb * m_loaded;
            rdy_e = (m_bytes < nb) && (bits < cb);
            checks++;
            if (o_s_ready !== rdy_e) begin
                errors++; $display("FAIL s_ready cyc %0d: got %b expected %b", cyc, o_s_ready, rdy_e);
            end
            checks++;
            if (o_m_valid !== m_mv) begin
                errors++; $display("FAIL m_valid cyc %0d: got %b expected %b", cyc, o_m_valid, m_mv);
            end
            if (m_mv && m_ready) begin
                checks++;
                if (o_m_data !== exp_q[hs] || o_m_last !== (hs == NC - 1)) begin
                    errors++;
                    $display("FAIL coef #%0d: got d=%h last=%b expected d=%h last=%b",
                             hs, o_m_data, o_m_last, exp_q[hs], (hs == NC - 1));
                end
                got.push_back(o_m_data);
                hs++;
            end
            hold      = m_mv && !m_ready;
            hold_data = o_m_data;
            acc = s_valid && rdy_e;
            pop = (!m_mv || m_ready) && (bits >= cb) && (m_loaded < NC);
            if (acc) m_bytes++;
            if (pop) begin m_loaded++; m_mv = 1'b1; end
            else if (m_ready) m_mv = 1'b0;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        if (hs < NC) begin
            checks++; errors++;
            $display("FAIL poly_complete: got %0d coefs expected %0d", hs, NC);
            return;
        end
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_m_valid !== 1'b0 || o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b mv=%b sr=%b expected 1 1 0 0",
                     o_done, o_busy, o_m_valid, o_s_ready);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL back_to_idle: got done=%b busy=%b expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({if2.s_ready, if2.m_valid, if2.m_last, if2.m_data, busy2, done2} !== 17'h0) begin
            errors++; $display("FAIL %s eta2: got outputs %h expected 0", tag,
                               {if2.s_ready, if2.m_valid, if2.m_last, if2.m_data, busy2, done2});
        end
        checks++;
        if ({if3.s_ready, if3.m_valid, if3.m_last, if3.m_data, busy3, done3} !== 17'h0) begin
            errors++; $display("FAIL %s eta3: got outputs %h expected 0", tag,
                               {if3.s_ready, if3.m_valid, if3.m_last, if3.m_data, busy3, done3});
        end
    endtask

    task automatic check_prefix(input string tag, input logic [11:0] want[8], input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== want[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %h expected %h", tag, i, (got.size() > i) ? got[i] : 12'hxxx, want[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; sel = 1'b0; s_data = 8'h00; s_valid = 1'b1; m_ready = 1'b1;
        #12;
        check_all_zero("reset_state");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle_ignores_s_valid");
        s_valid = 1'b0;
    endtask

    task automatic test_zero_eta2();
        int nz = 0;
        src.delete();
        for (int i = 0; i < 128; i++) src.push_back(8'h00);
        run_poly(2, 100, 100, -1, -1, -1);
        foreach (got[i]) if (got[i] !== 12'h000) nz++;
        checks++;
        if (got.size() != NC || nz != 0) begin
            errors++; $display("FAIL zero_poly: got %0d coefs (%0d nonzero) expected %0d all zero", got.size(), nz, NC);
        end
    endtask

    task automatic test_vectors_eta2();
        logic [11:0] want[8];
        fill_random(128);
        src[0] = 8'hEF; src[1] = 8'h03; src[2] = 8'h0C;
        want = '{enc(0), enc(-1), enc(2), enc(0), enc(-2), enc(0), 12'h000, 12'h000};
        run_poly(2, 100, 100, -1, -1, -1);
        check_prefix("eta2_vec", want, 6);
    endtask

    task automatic test_vectors_eta3();
        logic [11:0] want[8];
        fill_random(192);
        src[0] = 8'h07; src[1] = 8'h00; src[2] = 8'h00;
        src[3] = 8'h38; src[4] = 8'h00; src[5] = 8'h00;
        want = '{enc(3), enc(0), enc(0), enc(0), enc(-3), enc(0), enc(0), enc(0)};
        run_poly(3, 100, 100, -1, -1, -1);
        check_prefix("eta3_vec", want, 8);
    endtask

    task automatic test_back_to_back();
        fill_random(128);
        run_poly(2, 70, 60, 40, -1, -1);
        fill_random(192);
        run_poly(3, 60, 70, 90, -1, -1);
        fill_random(128);
        run_poly(2, 100, 35, 10, -1, -1);
    endtask

    task automatic test_reset_mid();
        fill_random(128);
        run_poly(2, 90, 80, -1, 100, -1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset_mid");
        @(negedge clk); reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        fill_random(128);
        run_poly(2, 80, 70, -1, -1, 50);
        fill_random(192);
        run_poly(3, 85, 75, -1, -1, 120);
    endtask

    initial begin
        test_reset();
        test_zero_eta2();
        test_vectors_eta2();
        test_vectors_eta3();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
